// File: rtl/acs_unit.sv
// ---------------------------------------------------------------------------
// acs_unit
//
// Add-compare-select stage for a 4-state, K=3, rate-1/2 hard-decision
// Viterbi decoder using the (7,5) code.
//
// Each accepted symbol pair goes through the following steps:
//   - Hamming branch metrics are formed for all eight trellis branches.
//   - The four path metrics are updated.
//   - One decision bit per state is produced for the survivor stage.
//   - The metrics renormalise themselves, so they never wrap.
//
// Optional build feature (macro ACS_BEST_STATE_EN):
//   When the macro is defined, the block adds the output best_state. It
//   holds the index of the smallest new path metric, and ties go to the
//   lowest index. When the macro is undefined, the port and its comparator
//   tree are absent.
//
// Parameters:
//   PMW        path-metric width in bits (5..16)
//   INIT_PM    start-of-frame metric for states 1..3 (state 0 starts at 0)
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high; reinitialises metrics, clears outputs
//   in_valid    rx holds a valid symbol pair this cycle
//   sof         start of frame; use initial metrics as the old metrics
//   rx          received hard bits {c0,c1}
//   dec_valid   dec/pm/norm were updated by an accepted symbol
//   dec         dec[n]=1: survivor into state n came from the odd predecessor
//   pm          path metrics, state n at bits [n*PMW +: PMW]
//   norm        pulses with dec_valid when the update was renormalised
//   best_state  (ACS_BEST_STATE_EN only) index of the minimum new metric
//
// Handshake:
//   There is no ready signal and no backpressure. Every cycle with
//   in_valid=1 consumes rx. The matching results appear one cycle later,
//   qualified by dec_valid, which is a single-cycle pulse per symbol.
//   Back-to-back symbols are accepted every cycle.
// ---------------------------------------------------------------------------
module acs_unit #(
    parameter int PMW     = 8,
    parameter int INIT_PM = 2 ** (PMW - 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             sof,
    input  logic [1:0]       rx,
    output logic             dec_valid,
    output logic [3:0]       dec,
    output logic [4*PMW-1:0] pm,
    output logic             norm
`ifdef ACS_BEST_STATE_EN
    ,
    output logic [1:0]       best_state
`endif
);

    localparam logic [PMW-1:0]        L_INIT      = PMW'(INIT_PM);
    localparam logic [3:0][PMW-1:0]   L_PM_INIT   = {L_INIT, L_INIT, L_INIT, {PMW{1'b0}}};
    localparam logic [PMW-1:0]        L_NORM_MASK = {1'b0, {(PMW-1){1'b1}}};

    // Registered state
    logic [3:0][PMW-1:0] r_pm;
    logic                r_dec_valid;
    logic [3:0]          r_dec;
    logic                r_norm;

    // Datapath
    logic [3:0][PMW-1:0] w_old_pm;
    logic [3:0][PMW:0]   w_sum_a;
    logic [3:0][PMW:0]   w_sum_b;
    logic [3:0][PMW:0]   w_sel;
    logic [3:0][PMW-1:0] w_new_pm;
    logic [3:0]          w_dec;
    logic [3:0]          w_top;
    logic                w_norm;
    logic                w_unused_carry;

    // Hamming distance between rx and the codeword of branch p --u-->.
    // The result is zero-extended to the candidate-sum width.
    // State p = {b1,b2}; c0 = u^b1^b2, c1 = u^b2.
    function automatic logic [PMW:0] f_bm(input logic [1:0] p, input logic u,
                                          input logic [1:0] rx_i);
        logic [1:0] cw;
        logic [1:0] diff;
        cw   = {u ^ p[1] ^ p[0], u ^ p[0]};
        diff = rx_i ^ cw;
        return (PMW+1)'(diff[1]) + (PMW+1)'(diff[0]);
    endfunction

    // On a start-of-frame cycle, the ACS runs from the initial metrics
    // instead of the stored ones.
    assign w_old_pm = sof ? L_PM_INIT : r_pm;

    // Add-compare-select. Next state n = {u, p[1]}, so u = n[1] and the
    // predecessors of n are 2*n[0] (even) and 2*n[0]+1 (odd). On a tie,
    // the even predecessor wins.
    always_comb begin
        w_sum_a = '0;
        w_sum_b = '0;
        w_sel   = '0;
        w_dec   = '0;
        w_top   = '0;
        for (int n = 0; n < 4; n++) begin
            w_sum_a[n] = {1'b0, w_old_pm[2*(n%2)]}
                       + f_bm(2'(2*(n%2)), 1'(n/2), rx);
            w_sum_b[n] = {1'b0, w_old_pm[2*(n%2)+1]}
                       + f_bm(2'(2*(n%2)+1), 1'(n/2), rx);
            w_dec[n]   = (w_sum_b[n] < w_sum_a[n]);
            w_sel[n]   = w_dec[n] ? w_sum_b[n] : w_sum_a[n];
            w_top[n]   = w_sel[n][PMW-1];
        end
    end

    // Renormalise when every survivor has its top bit set. Clearing that
    // bit subtracts the same amount from all four metrics, so the ordering
    // is preserved. The bounded metric spread keeps the carry bit at zero,
    // which is why it is only folded into an unused sink.
    assign w_norm = &w_top;

    always_comb begin
        w_new_pm = '0;
        for (int n = 0; n < 4; n++) begin
            w_new_pm[n] = w_sel[n][PMW-1:0] & (w_norm ? L_NORM_MASK : {PMW{1'b1}});
        end
    end

    assign w_unused_carry = ^{w_sel[3][PMW], w_sel[2][PMW], w_sel[1][PMW], w_sel[0][PMW]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pm        <= L_PM_INIT;
            r_dec_valid <= 1'b0;
            r_dec       <= 4'b0000;
            r_norm      <= 1'b0;
        end else if (in_valid) begin
            r_pm        <= w_new_pm;
            r_dec_valid <= 1'b1;
            r_dec       <= w_dec;
            r_norm      <= w_norm;
        end else begin
            // Idle cycle: metrics and dec hold, except that a lone sof
            // reloads the initial metrics.
            r_dec_valid <= 1'b0;
            r_norm      <= 1'b0;
            if (sof) begin
                r_pm <= L_PM_INIT;
            end
        end
    end

    assign pm        = r_pm;
    assign dec_valid = r_dec_valid;
    assign dec       = r_dec;
    assign norm      = r_norm;

`ifdef ACS_BEST_STATE_EN
    // Two-level minimum tree. At each level, a strict "<" keeps the lower
    // index on ties.
    logic [1:0]     r_best;
    logic [1:0]     w_best;
    logic           w_lo01;
    logic           w_lo23;
    logic [PMW-1:0] w_min01;
    logic [PMW-1:0] w_min23;

    always_comb begin
        w_lo01  = (w_new_pm[1] < w_new_pm[0]);
        w_lo23  = (w_new_pm[3] < w_new_pm[2]);
        w_min01 = w_lo01 ? w_new_pm[1] : w_new_pm[0];
        w_min23 = w_lo23 ? w_new_pm[3] : w_new_pm[2];
        w_best  = (w_min23 < w_min01) ? {1'b1, w_lo23} : {1'b0, w_lo01};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_best <= 2'd0;
        end else if (in_valid) begin
            r_best <= w_best;
        end else if (sof) begin
            r_best <= 2'd0;
        end
    end

    assign best_state = r_best;
`endif

endmodule

// File: tb/tb_acs_unit.sv
// ---------------------------------------------------------------------------
// tb_acs_unit
//
// Directed bench for acs_unit.
//
// Instance u8 (PMW=8, INIT_PM=64) covers these hand-computed trellis steps:
//   - reset state;
//   - first symbols after reset;
//   - tie handling;
//   - selection of the odd predecessor;
//   - idle gaps;
//   - sof with and without a symbol;
//   - reset in the middle of a stream.
//
// Instance u5 (PMW=5, INIT_PM=8) runs a long symbol stream. It is checked
// against an unbounded-integer reference, which is offset by 16 each time
// every reference metric has reached 16 above the current offset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acs_unit;

  // Clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // u8 signals
  logic        in_valid8, sof8;
  logic [1:0]  rx8;
  logic        dv8, norm8;
  logic [3:0]  dec8;
  logic [31:0] pm8;

  // u5 signals
  logic        in_valid5, sof5;
  logic [1:0]  rx5;
  logic        dv5, norm5;
  logic [3:0]  dec5;
  logic [19:0] pm5;

`ifdef ACS_BEST_STATE_EN
  logic [1:0]  bs8, bs5;
`endif

  acs_unit #(.PMW(8)) u8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid8),
    .sof       (sof8),
    .rx        (rx8),
    .dec_valid (dv8),
    .dec       (dec8),
    .pm        (pm8),
    .norm      (norm8)
`ifdef ACS_BEST_STATE_EN
    ,
    .best_state(bs8)
`endif
  );

  acs_unit #(.PMW(5)) u5 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid5),
    .sof       (sof5),
    .rx        (rx5),
    .dec_valid (dv5),
    .dec       (dec5),
    .pm        (pm5),
    .norm      (norm5)
`ifdef ACS_BEST_STATE_EN
    ,
    .best_state(bs5)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Checking
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk8(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic exp8(input string tag, input logic dv, input logic [3:0] d,
                      input logic [31:0] p, input logic nm, input int bs);
    chk({tag, "_dec_valid"}, 64'(dv8), 64'(dv));
    chk({tag, "_dec"}, 64'(dec8), 64'(d));
    chk({tag, "_pm"}, 64'(pm8), 64'(p));
    chk({tag, "_norm"}, 64'(norm8), 64'(nm));
`ifdef ACS_BEST_STATE_EN
    chk({tag, "_best"}, 64'(bs8), 64'(bs));
`else
    if (bs < 0) $display("unexpected best index %0d", bs);
`endif
  endtask

  // Driver
  task automatic drive8(input logic v, input logic s, input logic [1:0] r);
    in_valid8 = v;
    sof8      = s;
    rx8       = r;
    @(posedge clk);
    #1;
  endtask

  // Reference model (unbounded metrics)
  function automatic int bm_f(input int p, input int u, input logic [1:0] r);
    logic [1:0] pp;
    logic       uu;
    logic [1:0] cw;
    pp = 2'(p);
    uu = 1'(u);
    cw = {uu ^ pp[1] ^ pp[0], uu ^ pp[0]};
    return int'(cw[1] ^ r[1]) + int'(cw[0] ^ r[0]);
  endfunction

  int          ref_pm[4];
  int          new_pm[4];
  int          off;
  logic [3:0]  exp_dec;
  logic        exp_norm;
  logic [19:0] exp_pm5;
  int          exp_bs;
  int          norm_seen_dut;
  int          norm_seen_ref;

  initial begin
    reset     = 1'b1;
    in_valid8 = 1'b0; sof8 = 1'b0; rx8 = 2'b00;
    in_valid5 = 1'b0; sof5 = 1'b0; rx5 = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state
    exp8("reset", 1'b0, 4'h0, pk8(0, 64, 64, 64), 1'b0, 0);
    chk("reset_u5_pm", 64'(pm5), 64'({5'd8, 5'd8, 5'd8, 5'd0}));
    chk("reset_u5_dv", 64'(dv5), 64'(0));
    reset = 1'b0;

    // rx=00 twice after reset
    drive8(1'b1, 1'b0, 2'b00);
    exp8("s00_a", 1'b1, 4'h0, pk8(0, 65, 2, 65), 1'b0, 0);
    drive8(1'b1, 1'b0, 2'b00);
    exp8("s00_b", 1'b1, 4'h0, pk8(0, 3, 2, 3), 1'b0, 0);
    drive8(1'b0, 1'b0, 2'b11);
    exp8("s00_idle", 1'b0, 4'h0, pk8(0, 3, 2, 3), 1'b0, 0);

    // Tie break, then odd-predecessor path
    reset = 1'b1;
    drive8(1'b0, 1'b0, 2'b00);
    reset = 1'b0;
    exp8("reset2", 1'b0, 4'h0, pk8(0, 64, 64, 64), 1'b0, 0);
    drive8(1'b1, 1'b0, 2'b11);
    exp8("tie", 1'b1, 4'h0, pk8(2, 65, 0, 65), 1'b0, 2);
    drive8(1'b1, 1'b0, 2'b10);
    exp8("odd_b", 1'b1, 4'h0, pk8(3, 0, 3, 2), 1'b0, 1);
    drive8(1'b1, 1'b0, 2'b11);
    exp8("odd_c", 1'b1, 4'hF, pk8(0, 3, 2, 3), 1'b0, 0);

    // Idle gaps hold metrics and dec
    drive8(1'b0, 1'b0, 2'b10);
    exp8("gap1", 1'b0, 4'hF, pk8(0, 3, 2, 3), 1'b0, 0);
    drive8(1'b0, 1'b0, 2'b01);
    exp8("gap2", 1'b0, 4'hF, pk8(0, 3, 2, 3), 1'b0, 0);
    drive8(1'b1, 1'b0, 2'b01);
    exp8("gap_sym", 1'b1, 4'b0010, pk8(1, 3, 1, 2), 1'b0, 0);

    // sof on an idle cycle, then sof together with a symbol
    drive8(1'b0, 1'b1, 2'b11);
    exp8("sof_only", 1'b0, 4'b0010, pk8(0, 64, 64, 64), 1'b0, 0);
    drive8(1'b1, 1'b0, 2'b11);
    exp8("pre_sof", 1'b1, 4'h0, pk8(2, 65, 0, 65), 1'b0, 2);
    drive8(1'b1, 1'b1, 2'b00);
    exp8("sof_valid", 1'b1, 4'h0, pk8(0, 65, 2, 65), 1'b0, 0);

    // Reset in the middle of a stream
    drive8(1'b1, 1'b0, 2'b11);
    exp8("stream", 1'b1, 4'h0, pk8(2, 3, 0, 3), 1'b0, 2);
    reset = 1'b1;
    drive8(1'b1, 1'b0, 2'b10);
    reset = 1'b0;
    exp8("mid_reset", 1'b0, 4'h0, pk8(0, 64, 64, 64), 1'b0, 0);
    drive8(1'b1, 1'b0, 2'b00);
    exp8("restart_a", 1'b1, 4'h0, pk8(0, 65, 2, 65), 1'b0, 0);
    drive8(1'b1, 1'b0, 2'b00);
    exp8("restart_b", 1'b1, 4'h0, pk8(0, 3, 2, 3), 1'b0, 0);
    drive8(1'b0, 1'b0, 2'b00);

    // PMW=5 stream against the unbounded reference
    ref_pm[0] = 0; ref_pm[1] = 8; ref_pm[2] = 8; ref_pm[3] = 8;
    off = 0;
    norm_seen_dut = 0;
    norm_seen_ref = 0;
    for (int k = 0; k < 300; k++) begin
      in_valid5 = 1'b1;
      sof5      = (k == 0);
      rx5       = 2'($urandom_range(0, 3));
      @(posedge clk); #1;

      for (int n = 0; n < 4; n++) begin
        new_pm[n]  = -1;
        exp_dec[n] = 1'b0;
        for (int p = 0; p < 4; p++) begin
          for (int u = 0; u < 2; u++) begin
            if ((u * 2 + p / 2) == n) begin
              if (new_pm[n] < 0 || ref_pm[p] + bm_f(p, u, rx5) < new_pm[n]) begin
                new_pm[n]  = ref_pm[p] + bm_f(p, u, rx5);
                exp_dec[n] = 1'(p % 2);
              end
            end
          end
        end
      end
      exp_norm = 1'b1;
      for (int n = 0; n < 4; n++) begin
        ref_pm[n] = new_pm[n];
        if (ref_pm[n] - off < 16) exp_norm = 1'b0;
      end
      if (exp_norm) begin
        off = off + 16;
        norm_seen_ref++;
      end
      exp_bs = 0;
      for (int n = 0; n < 4; n++) begin
        exp_pm5[n*5 +: 5] = 5'(ref_pm[n] - off);
        if (ref_pm[n] < ref_pm[exp_bs]) exp_bs = n;
      end
      if (norm5 === 1'b1) norm_seen_dut++;

      chk($sformatf("u5_dv_%0d", k), 64'(dv5), 64'(1));
      chk($sformatf("u5_dec_%0d", k), 64'(dec5), 64'(exp_dec));
      chk($sformatf("u5_pm_%0d", k), 64'(pm5), 64'(exp_pm5));
      chk($sformatf("u5_norm_%0d", k), 64'(norm5), 64'(exp_norm));
`ifdef ACS_BEST_STATE_EN
      chk($sformatf("u5_best_%0d", k), 64'(bs5), 64'(exp_bs));
`endif
    end
    chk("u5_norm_count", 64'(norm_seen_dut), 64'(norm_seen_ref));
    chk("u5_norm_exercised", 64'(norm_seen_ref > 0), 64'(1));

    in_valid5 = 1'b0;
    sof5      = 1'b0;
    @(posedge clk); #1;
    chk("u5_idle_dv", 64'(dv5), 64'(0));
    chk("u5_idle_pm", 64'(pm5), 64'(exp_pm5));
    chk("u5_idle_norm", 64'(norm5), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
